// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive frame checker.
// FSM states, parity-mode encodings and DATA_WIDTH legal range.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_e;

  localparam logic [1:0] PAR_EVEN  = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_MARK  = 2'b10;
  localparam logic [1:0] PAR_SPACE = 2'b11;

  localparam int DW_MIN = 5;
  localparam int DW_MAX = 9;

endpackage

// File: rtl/uart_par_calc.sv
// Expected parity bit from the running data parity and the parity mode.
// Purely combinational.
module uart_par_calc
  import uart_pkg::*;
(
  input  logic       run_par_i,
  input  logic [1:0] mode_i,
  output logic       exp_o
);

  // Map the mode onto the bit the transmitter should have sent
  always_comb begin
    exp_o = run_par_i;
    unique case (mode_i)
      PAR_EVEN:  exp_o = run_par_i;
      PAR_ODD:   exp_o = ~run_par_i;
      PAR_MARK:  exp_o = 1'b1;
      PAR_SPACE: exp_o = 1'b0;
      default:   exp_o = run_par_i;
    endcase
  end

endmodule

// File: rtl/uart_rx_frame_check.sv
// UART receive frame assembler with parity/stop checking.
// Error counters present only when UART_RX_ERR_CNT_EN is defined.
module uart_rx_frame_check
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  frame_start,
  input  logic                  bit_valid,
  input  logic                  sampled_bit,
  input  logic                  par_en,
  input  logic [1:0]            parity_mode,
  input  logic                  stop2,
  input  logic                  cnt_clr,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  par_err_cnt,
  output logic [CNT_WIDTH-1:0]  stp_err_cnt
);

  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    run_par_q, run_par_d;
  logic                    par_fail_q, par_fail_d;
  logic                    stp_fail_q, stp_fail_d;
  logic                    par_en_q, par_en_d;
  logic [1:0]              mode_q, mode_d;
  logic                    stop2_q, stop2_d;
  logic                    stop_n_q, stop_n_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    dv_q, dv_d;
  logic                    par_err_q, par_err_d;
  logic                    stp_err_q, stp_err_d;
  logic                    done;
  logic                    par_exp;

  uart_par_calc u_par_calc (
    .run_par_i (run_par_q),
    .mode_i    (mode_q),
    .exp_o     (par_exp)
  );

  // Next-state and datapath updates; frame_start overrides any bit strobe
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    run_par_d  = run_par_q;
    par_fail_d = par_fail_q;
    stp_fail_d = stp_fail_q;
    par_en_d   = par_en_q;
    mode_d     = mode_q;
    stop2_d    = stop2_q;
    stop_n_d   = stop_n_q;
    data_d     = data_q;
    dv_d       = 1'b0;
    par_err_d  = par_err_q;
    stp_err_d  = stp_err_q;
    done       = 1'b0;

    if (frame_start) begin
      state_d    = ST_DATA;
      idx_d      = '0;
      run_par_d  = 1'b0;
      par_fail_d = 1'b0;
      stp_fail_d = 1'b0;
      stop_n_d   = 1'b0;
      par_en_d   = par_en;
      mode_d     = parity_mode;
      stop2_d    = stop2;
    end else if (bit_valid) begin
      unique case (state_q)
        ST_DATA: begin
          for (int i = 0; i < DATA_WIDTH; i++) begin
            if (idx_q == IDX_W'(i)) data_d[i] = sampled_bit;
          end
          run_par_d = run_par_q ^ sampled_bit;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = par_en_q ? ST_PARITY : ST_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        ST_PARITY: begin
          par_fail_d = (sampled_bit != par_exp);
          state_d    = ST_STOP;
        end
        ST_STOP: begin
          stp_fail_d = stp_fail_q | ~sampled_bit;
          stop_n_d   = 1'b1;
          if (!stop2_q || stop_n_q) begin
            state_d = ST_IDLE;
            done    = 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (done) begin
      dv_d      = 1'b1;
      par_err_d = par_en_q & par_fail_d;
      stp_err_d = stp_fail_d;
    end
  end

  // Frame state and status registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      run_par_q  <= 1'b0;
      par_fail_q <= 1'b0;
      stp_fail_q <= 1'b0;
      par_en_q   <= 1'b0;
      mode_q     <= PAR_EVEN;
      stop2_q    <= 1'b0;
      stop_n_q   <= 1'b0;
      data_q     <= '0;
      dv_q       <= 1'b0;
      par_err_q  <= 1'b0;
      stp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      run_par_q  <= run_par_d;
      par_fail_q <= par_fail_d;
      stp_fail_q <= stp_fail_d;
      par_en_q   <= par_en_d;
      mode_q     <= mode_d;
      stop2_q    <= stop2_d;
      stop_n_q   <= stop_n_d;
      data_q     <= data_d;
      dv_q       <= dv_d;
      par_err_q  <= par_err_d;
      stp_err_q  <= stp_err_d;
    end
  end

`ifdef UART_RX_ERR_CNT_EN
  logic [CNT_WIDTH-1:0] pcnt_q, pcnt_d;
  logic [CNT_WIDTH-1:0] scnt_q, scnt_d;

  // Saturating error counters; a clear wins over a same-cycle increment
  always_comb begin
    pcnt_d = pcnt_q;
    scnt_d = scnt_q;
    if (cnt_clr) begin
      pcnt_d = '0;
      scnt_d = '0;
    end else if (done) begin
      if (par_err_d && pcnt_q != '1) pcnt_d = pcnt_q + 1'b1;
      if (stp_err_d && scnt_q != '1) scnt_d = scnt_q + 1'b1;
    end
  end

  // Counter registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pcnt_q <= '0;
      scnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
      scnt_q <= scnt_d;
    end
  end

  assign par_err_cnt = pcnt_q;
  assign stp_err_cnt = scnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign par_err_cnt    = '0;
  assign stp_err_cnt    = '0;
`endif

  assign P_DATA     = data_q;
  assign data_valid = dv_q;
  assign par_err    = par_err_q;
  assign stp_err    = stp_err_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// Directed bench for uart_rx_frame_check (DATA_WIDTH=8, CNT_WIDTH=8).
// Frame table plus abort, reset and counter-saturation sequences.
module tb_uart_rx_frame_check;

  localparam int DW = 8;
  localparam int CW = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic          frame_start, bit_valid, sampled_bit;
  logic          par_en, stop2, cnt_clr;
  logic [1:0]    parity_mode;
  logic [DW-1:0] P_DATA;
  logic          data_valid, par_err, stp_err, busy;
  logic [CW-1:0] par_err_cnt, stp_err_cnt;

  uart_rx_frame_check #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .frame_start (frame_start),
    .bit_valid   (bit_valid),
    .sampled_bit (sampled_bit),
    .par_en      (par_en),
    .parity_mode (parity_mode),
    .stop2       (stop2),
    .cnt_clr     (cnt_clr),
    .P_DATA      (P_DATA),
    .data_valid  (data_valid),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .busy        (busy),
    .par_err_cnt (par_err_cnt),
    .stp_err_cnt (stp_err_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic [1:0] mode;
    logic       s2;
    logic       pbit;
    logic [1:0] stops;
    logic       exp_pe;
    logic       exp_se;
  } vec_t;

  vec_t vecs[8];
  int   checks = 0;
  int   errors = 0;
  int   exp_pc = 0;
  int   exp_sc = 0;
  int   dv_count = 0;
  logic early;

  always @(negedge CLK) if (data_valid === 1'b1) dv_count++;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model(input logic pe, input logic se, input logic clr);
`ifdef UART_RX_ERR_CNT_EN
    if (clr) begin
      exp_pc = 0;
      exp_sc = 0;
    end else begin
      if (pe && exp_pc != 255) exp_pc++;
      if (se && exp_sc != 255) exp_sc++;
    end
`else
    exp_pc = 0;
    exp_sc = 0;
`endif
  endtask

  task automatic start(input logic pe, input logic [1:0] md,
                       input logic s2, input logic bv);
    @(negedge CLK);
    frame_start = 1'b1;
    par_en      = pe;
    parity_mode = md;
    stop2       = s2;
    bit_valid   = bv;
    sampled_bit = 1'b1;
    @(posedge CLK);
    #1;
    frame_start = 1'b0;
    bit_valid   = 1'b0;
  endtask

  task automatic drive_bit(input logic b, input logic clr);
    @(negedge CLK);
    sampled_bit = b;
    bit_valid   = 1'b1;
    cnt_clr     = clr;
    @(posedge CLK);
    #1;
    bit_valid = 1'b0;
    cnt_clr   = 1'b0;
  endtask

  // Ends one cycle after the final stop-bit strobe was sampled
  task automatic send_frame(input vec_t v, input logic clr_last);
    logic bits[$];
    bits = {};
    for (int i = 0; i < 8; i++) bits.push_back(v.data[i]);
    if (v.pe) bits.push_back(v.pbit);
    bits.push_back(v.stops[0]);
    if (v.s2) bits.push_back(v.stops[1]);
    early = 1'b0;
    start(v.pe, v.mode, v.s2, 1'b0);
    for (int i = 0; i < bits.size(); i++) begin
      if (i == bits.size() - 1) begin
        drive_bit(bits[i], clr_last);
      end else begin
        drive_bit(bits[i], 1'b0);
        early = early | data_valid;
      end
    end
  endtask

  initial begin
    int dv0;
    vecs[0] = '{8'hA5, 1'b1, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0};
    vecs[1] = '{8'hA5, 1'b1, 2'b01, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0};
    vecs[2] = '{8'h3C, 1'b0, 2'b00, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1};
    vecs[3] = '{8'h01, 1'b1, 2'b10, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1};
    vecs[4] = '{8'hFF, 1'b1, 2'b11, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0};
    vecs[5] = '{8'h80, 1'b1, 2'b01, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0};
    vecs[6] = '{8'h00, 1'b0, 2'b00, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0};
    vecs[7] = '{8'h5A, 1'b1, 2'b00, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0};

    RST = 1'b1;
    frame_start = 1'b0; bit_valid = 1'b0; sampled_bit = 1'b1;
    par_en = 1'b0; parity_mode = 2'b00; stop2 = 1'b0; cnt_clr = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK); #1;
    chk("rst_pdata", P_DATA, 0);
    chk("rst_dv", data_valid, 0);
    chk("rst_flags", {par_err, stp_err, busy}, 0);
    chk("rst_cnt", {par_err_cnt, stp_err_cnt}, 0);

    for (int i = 0; i < 8; i++) begin
      send_frame(vecs[i], 1'b0);
      model(vecs[i].exp_pe, vecs[i].exp_se, 1'b0);
      chk($sformatf("v%0d_pdata", i), P_DATA, vecs[i].data);
      chk($sformatf("v%0d_dv", i), data_valid, 1);
      chk($sformatf("v%0d_par", i), par_err, vecs[i].exp_pe);
      chk($sformatf("v%0d_stp", i), stp_err, vecs[i].exp_se);
      chk($sformatf("v%0d_pcnt", i), par_err_cnt, exp_pc);
      chk($sformatf("v%0d_scnt", i), stp_err_cnt, exp_sc);
      chk($sformatf("v%0d_early_dv", i), early, 0);
      @(posedge CLK); #1;
      chk($sformatf("v%0d_dv_pulse", i), data_valid, 0);
      chk($sformatf("v%0d_hold", i), {P_DATA, par_err, stp_err},
          {vecs[i].data, vecs[i].exp_pe, vecs[i].exp_se});
    end

    // Asynchronous reset in the middle of the data bits
    start(1'b1, 2'b00, 1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b0);
    chk("mid_busy", busy, 1);
    @(negedge CLK); #2;
    RST = 1'b1;
    #1;
    chk("async_pdata", P_DATA, 0);
    chk("async_flags", {data_valid, par_err, stp_err, busy}, 0);
    chk("async_cnt", {par_err_cnt, stp_err_cnt}, 0);
    model(1'b0, 1'b0, 1'b1);
    @(negedge CLK);
    RST = 1'b0;

    // Abort mid-frame, restart with a coincident bit strobe, then 0x3C
    dv0 = dv_count;
    start(1'b1, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0);
    start(1'b0, 2'b00, 1'b0, 1'b1);
    chk("abort_busy", busy, 1);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] w;
      w = 8'h3C;
      drive_bit(w[i], 1'b0);
    end
    drive_bit(1'b1, 1'b0);
    chk("abort_dv", data_valid, 1);
    chk("abort_pdata", P_DATA, 8'h3C);
    chk("abort_flags", {par_err, stp_err}, 0);
    chk("abort_cnt", {par_err_cnt, stp_err_cnt}, {exp_pc[7:0], exp_sc[7:0]});
    repeat (3) @(posedge CLK);
    #1;
    chk("abort_dv_count", dv_count - dv0, 1);
    chk("idle_busy", busy, 0);

    // Ignored strobe in IDLE must not disturb the held word
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b0, 1'b0);
    chk("idle_ignore", {P_DATA, busy, data_valid}, {8'h3C, 2'b00});

    // Counter saturation and clear coinciding with an error completion
    for (int i = 0; i < 260; i++) begin
      send_frame(vecs[1], 1'b0);
      model(1'b1, 1'b0, 1'b0);
    end
    chk("sat_pcnt", par_err_cnt, exp_pc);
    chk("sat_par", par_err, 1);
    send_frame(vecs[1], 1'b1);
    model(1'b1, 1'b0, 1'b1);
    chk("clr_pcnt", par_err_cnt, exp_pc);
    chk("clr_par", par_err, 1);
    send_frame(vecs[1], 1'b0);
    model(1'b1, 1'b0, 1'b0);
    chk("post_clr_pcnt", par_err_cnt, exp_pc);
    send_frame(vecs[3], 1'b0);
    model(1'b0, 1'b1, 1'b0);
    chk("post_clr_scnt", stp_err_cnt, exp_sc);
    chk("post_clr_pcnt2", par_err_cnt, exp_pc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_check.md
UART_RX_FRAME_CHECK -- requirements
Module: uart_rx_frame_check

Interface
REQ-001 Parameter DATA_WIDTH, default 8, data bits per frame, legal 5..9.
REQ-002 Parameter CNT_WIDTH, default 8, width of each error counter.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset: CLK input 1, sole clock, rising edge.
REQ-004 RST input 1, asynchronous, active-high reset.
REQ-005 frame_start input 1, one-cycle pulse marking that the start bit was accepted.
REQ-006 bit_valid input 1, one-cycle strobe qualifying sampled_bit.
REQ-007 sampled_bit input 1, majority-sampled line value.
REQ-008 par_en input 1, 1 means a parity bit follows the data bits.
REQ-009 parity_mode input 2, 00 even, 01 odd, 10 mark, 11 space.
REQ-010 stop2 input 1, 1 means two stop bits, 0 means one.
REQ-011 cnt_clr input 1, synchronous clear of the error counters.
REQ-012 P_DATA output DATA_WIDTH, received word, LSB first on the line.
REQ-013 data_valid output 1, one-cycle pulse when a frame completes.
REQ-014 par_err, stp_err output 1 each, status of the last completed frame.
REQ-015 busy output 1, high in any state other than IDLE.
REQ-016 par_err_cnt, stp_err_cnt output CNT_WIDTH each, error counters.

Function
REQ-017 FSM states: IDLE, DATA, PARITY, STOP; busy = (state != IDLE).
REQ-018 frame_start SHALL latch par_en/parity_mode/stop2, clear bit index and running parity, and enter DATA from any state.
REQ-019 frame_start outside IDLE SHALL abort the current frame: no data_valid, no flag or counter update.
REQ-020 frame_start and bit_valid in the same cycle: frame_start wins and the bit is discarded.
REQ-021 DATA: each bit_valid writes sampled_bit to P_DATA[index] and XORs it into the running parity; after DATA_WIDTH bits the FSM goes to PARITY if par_en is latched, else to STOP.
REQ-022 PARITY: expected bit is running parity (00), its inverse (01), 1 (10) or 0 (11); mismatch sets the internal parity-fail flag; next state is STOP.
REQ-023 STOP: any stop bit equal to 0 sets the internal stop-fail flag; after 1 or 2 stop bits (per latched stop2) the FSM returns to IDLE.
REQ-024 Completion: data_valid is high exactly the cycle after the final stop-bit bit_valid, and par_err/stp_err load from the internal flags in that same cycle.
REQ-025 par_err/stp_err SHALL hold until the next completion; par_err SHALL be 0 when par_en was latched 0.
REQ-026 P_DATA SHALL be stable from data_valid until the next frame_start.
REQ-027 bit_valid in IDLE SHALL be ignored.
REQ-028 Counters increment by 1 at completion per asserted error and saturate at all-ones.
REQ-029 cnt_clr coincident with an increment SHALL yield 0.

Reset
REQ-030 RST SHALL force state IDLE, P_DATA 0, data_valid 0, par_err 0, stp_err 0, both counters 0 and busy 0; an in-flight frame is discarded.

Configuration
REQ-031 Macro UART_RX_ERR_CNT_EN: when defined, the counters and cnt_clr behave as in REQ-028/029; when undefined, no counter registers exist, par_err_cnt/stp_err_cnt are tied to 0 and cnt_clr is ignored.

Structure
REQ-032 Shared package uart_pkg SHALL hold the FSM state enum, the parity_mode encodings (PAR_EVEN, PAR_ODD, PAR_MARK, PAR_SPACE) and the DATA_WIDTH legal-range constants.
REQ-033 Sub-module uart_par_calc SHALL be purely combinational, mapping running parity and mode to the expected parity bit.

Verification
REQ-034 DATA_WIDTH=8, even parity, 1 stop bit, byte 0xA5, parity bit 0, stop bit 1 -> P_DATA=0xA5, data_valid one cycle, par_err=0, stp_err=0.
REQ-035 Same frame sent as odd parity with parity bit 0 -> par_err=1, par_err_cnt 0->1.
REQ-036 stop2=1, second stop bit 0 -> stp_err=1, data_valid only after the second stop bit.
REQ-037 frame_start after 4 data bits, then a clean frame carrying 0x3C -> exactly one data_valid, P_DATA=0x3C, counters unchanged.
REQ-038 Force 260 parity errors with CNT_WIDTH=8 -> par_err_cnt saturates at 255; cnt_clr asserted on the cycle of an error completion -> counter reads 0.
REQ-039 RST asserted mid-DATA -> all outputs 0 immediately (asynchronously); a frame started after release decodes correctly.
